aclk_controller: RTL and testbench

Keypad sequencing controller for the alarm clock. It collects up to four BCD digits from the keypad into an entry register, validates the entry, and then issues a one-cycle load pulse. That pulse goes to the time counter (`load_new_c`) or to the alarm register (`load_new_a`). It also drives the display-select lines (`show_a`, `show_new_time`) and abandons an idle entry after a programmable number of seconds. It sits between the keypad scanner and `aclk_counter` / the alarm register, and its `new_time_*` outputs feed both.

---
 rtl/aclk_pkg.sv | 40 ++++
 rtl/aclk_if.sv | 33 +++
 rtl/aclk_key_reg.sv | 49 ++++
 rtl/aclk_controller.sv | 121 ++++++++++++
 tb/tb_aclk_controller.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aclk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_pkg
//  Description : Shared types and constants for the alarm-clock keypad
//                sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package aclk_pkg;

    // Controller FSM encoding
    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAIT   = 3'd2,
        KEY_ENTRY  = 3'd3,
        SET_TIME   = 3'd4,
        SET_ALARM  = 3'd5,
        SHOW_ALARM = 3'd6,
        ERROR      = 3'd7
    } state_t;

    // Keypad command codes
    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    localparam int DEFAULT_TIMEOUT_S = 10;

    // Keypad codes 0..9 are digits
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    // Codes C..F all mean "no key pressed"
    function automatic logic is_released(input logic [3:0] k);
        return (k >= 4'hC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_if.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_if
//  Description : Keypad/display bundle between the keypad side (master) and
//                the sequencing controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface aclk_if;
    logic       one_second;
    logic [3:0] key;
    logic [3:0] new_time_ms_hr;
    logic [3:0] new_time_ls_hr;
    logic [3:0] new_time_ms_min;
    logic [3:0] new_time_ls_min;
    logic       load_new_c;
    logic       load_new_a;
    logic       show_a;
    logic       show_new_time;
    logic       entry_error;

    modport master (
        output one_second, key,
        input  new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
        input  load_new_c, load_new_a, show_a, show_new_time, entry_error
    );

    modport slave (
        input  one_second, key,
        output new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
        output load_new_c, load_new_a, show_a, show_new_time, entry_error
    );
endinterface
`default_nettype wire

// File: rtl/aclk_key_reg.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_key_reg
//  Description : Four-digit BCD entry register with shift/clear and an
//                hh:mm validity check.
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_key_reg (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       clear,
    input  wire logic       shift,
    input  wire logic [3:0] key,
    output logic      [3:0] ms_hr,
    output logic      [3:0] ls_hr,
    output logic      [3:0] ms_min,
    output logic      [3:0] ls_min,
    output logic            valid
);

    logic [15:0] r_entry;
    logic [7:0]  w_hours;

    // Shift a digit in on the right; clear+shift starts a fresh entry 000d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry <= 16'h0000;
        end else if (shift) begin
            r_entry <= clear ? {12'h000, key} : {r_entry[11:0], key};
        end else if (clear) begin
            r_entry <= 16'h0000;
        end
    end

    assign ms_hr  = r_entry[15:12];
    assign ls_hr  = r_entry[11:8];
    assign ms_min = r_entry[7:4];
    assign ls_min = r_entry[3:0];

    assign w_hours = ({4'd0, ms_hr} * 8'd10) + {4'd0, ls_hr};

    // Legal 24-hour time: 00:00 .. 23:59 with every digit a proper BCD value
    always_comb begin
        valid = (ms_hr <= 4'd2) && (ls_hr <= 4'd9) && (w_hours <= 8'd23) &&
                (ms_min <= 4'd5) && (ls_min <= 4'd9);
    end

endmodule
`default_nettype wire

// File: rtl/aclk_controller.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_controller
//  Description : Keypad sequencing controller: digit entry, validation,
//                counter/alarm load pulses, display select and idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_controller
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_S = DEFAULT_TIMEOUT_S
) (
    input  wire logic clk,
    input  wire logic reset,
    aclk_if.slave     bus
);

    localparam logic [3:0] c_last_count = 4'(TIMEOUT_S - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_count;
    logic       w_clear;
    logic       w_shift;
    logic       w_valid;
    logic       w_timeout;
    logic       w_idle;

    aclk_key_reg u_key_reg (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .shift  (w_shift),
        .key    (bus.key),
        .ms_hr  (bus.new_time_ms_hr),
        .ls_hr  (bus.new_time_ls_hr),
        .ms_min (bus.new_time_ms_min),
        .ls_min (bus.new_time_ls_min),
        .valid  (w_valid)
    );

    // Timeout only runs while waiting for the user inside an entry
    assign w_idle    = (r_state == KEY_WAIT) || (r_state == KEY_ENTRY);
    assign w_timeout = bus.one_second && (r_count == c_last_count);

    // Seconds-without-keypress counter; any other state restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (!w_idle) begin
            r_count <= 4'd0;
        end else if (bus.one_second) begin
            r_count <= r_count + 4'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SHOW_TIME;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and entry-register control; keys take priority over timeout
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            SHOW_TIME: begin
                if (is_digit(bus.key)) begin
                    w_clear = 1'b1;
                    w_shift = 1'b1;
                    w_next  = KEY_STORED;
                end else if (bus.key == KEY_ALARM) begin
                    w_next = SHOW_ALARM;
                end
            end
            KEY_STORED: w_next = KEY_WAIT;
            KEY_WAIT: begin
                if (is_released(bus.key)) begin
                    w_next = KEY_ENTRY;
                end else if (w_timeout) begin
                    w_next = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (is_digit(bus.key)) begin
                    w_shift = 1'b1;
                    w_next  = KEY_STORED;
                end else if (bus.key == KEY_TIME) begin
                    w_next = w_valid ? SET_TIME : ERROR;
                end else if (bus.key == KEY_ALARM) begin
                    w_next = w_valid ? SET_ALARM : ERROR;
                end else if (w_timeout) begin
                    w_next = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (bus.key != KEY_ALARM) begin
                    w_next = SHOW_TIME;
                end
            end
            default: w_next = SHOW_TIME;
        endcase
    end

    // Moore output decode
    always_comb begin
        bus.load_new_c    = (r_state == SET_TIME);
        bus.load_new_a    = (r_state == SET_ALARM);
        bus.entry_error   = (r_state == ERROR);
        bus.show_a        = (r_state == SHOW_ALARM);
        bus.show_new_time = (r_state == KEY_STORED) || (r_state == KEY_WAIT) ||
                            (r_state == KEY_ENTRY)  || (r_state == SET_ALARM);
    end

endmodule
`default_nettype wire

// File: tb/tb_aclk_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aclk_controller
//  Description : Directed self-checking bench for aclk_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aclk_controller;
    import aclk_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] entry;
    int          n_tests = 0;
    int          n_fail  = 0;

    aclk_if bus();

    aclk_controller #(.TIMEOUT_S(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign entry = {bus.new_time_ms_hr, bus.new_time_ls_hr,
                    bus.new_time_ms_min, bus.new_time_ls_min};

    // Drive one cycle of inputs, then settle just after the edge
    task automatic step(input logic [3:0] k, input logic os);
        bus.key        = k;
        bus.one_second = os;
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d, input int hold);
        repeat (hold) step(d, 1'b0);
        step(KEY_NONE, 1'b0);
        step(KEY_NONE, 1'b0);
    endtask

    task automatic enter4(input logic [15:0] v);
        press_digit(v[15:12], 2);
        press_digit(v[11:8], 2);
        press_digit(v[7:4], 2);
        press_digit(v[3:0], 2);
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        bus.key        = KEY_NONE;
        bus.one_second = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.load_new_c, bus.load_new_a, bus.show_a, bus.show_new_time, bus.entry_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.load_new_c, bus.load_new_a, bus.show_a, bus.show_new_time, bus.entry_error});
        end
        n_tests++;
        if (entry !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_entry: got %h want 0000", entry);
        end
        @(negedge clk);
        reset = 1'b1;
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_set_time;
        enter4(16'h1234);
        n_tests++;
        if (bus.show_new_time !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_show_new: got %b want 1", bus.show_new_time);
        end
        step(KEY_TIME, 1'b0);
        n_tests++;
        if (bus.load_new_c !== 1'b1 || entry !== 16'h1234 || bus.load_new_a !== 1'b0) begin
            n_fail++;
            $display("FAIL set_time_load: got c=%b a=%b entry=%h want c=1 a=0 entry=1234",
                     bus.load_new_c, bus.load_new_a, entry);
        end
        step(KEY_NONE, 1'b0);
        n_tests++;
        if (bus.load_new_c !== 1'b0 || bus.show_new_time !== 1'b0 || entry !== 16'h1234) begin
            n_fail++;
            $display("FAIL set_time_end: got c=%b show_new=%b entry=%h want 0 0 1234",
                     bus.load_new_c, bus.show_new_time, entry);
        end
        step(KEY_ALARM, 1'b0);
        n_tests++;
        if (bus.show_a !== 1'b1) begin
            n_fail++;
            $display("FAIL set_time_back_idle: show_a got %b want 1", bus.show_a);
        end
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_set_alarm;
        enter4(16'h0630);
        step(KEY_ALARM, 1'b0);
        n_tests++;
        if (bus.load_new_a !== 1'b1 || bus.load_new_c !== 1'b0 || entry !== 16'h0630 ||
            bus.show_new_time !== 1'b1) begin
            n_fail++;
            $display("FAIL set_alarm_load: got a=%b c=%b entry=%h show_new=%b want 1 0 0630 1",
                     bus.load_new_a, bus.load_new_c, entry, bus.show_new_time);
        end
        step(KEY_NONE, 1'b0);
        n_tests++;
        if (bus.load_new_a !== 1'b0 || bus.show_a !== 1'b0) begin
            n_fail++;
            $display("FAIL set_alarm_end: got a=%b show_a=%b want 0 0", bus.load_new_a, bus.show_a);
        end
    endtask

    task automatic test_error;
        enter4(16'h2500);
        step(KEY_TIME, 1'b0);
        n_tests++;
        if (bus.entry_error !== 1'b1 || bus.load_new_c !== 1'b0 || bus.load_new_a !== 1'b0) begin
            n_fail++;
            $display("FAIL error_pulse: got err=%b c=%b a=%b want 1 0 0",
                     bus.entry_error, bus.load_new_c, bus.load_new_a);
        end
        step(KEY_NONE, 1'b0);
        n_tests++;
        if (bus.entry_error !== 1'b0 || bus.show_new_time !== 1'b0) begin
            n_fail++;
            $display("FAIL error_end: got err=%b show_new=%b want 0 0", bus.entry_error, bus.show_new_time);
        end
    endtask

    task automatic test_held_digit;
        press_digit(4'd5, 20);
        step(KEY_TIME, 1'b0);
        n_tests++;
        if (bus.load_new_c !== 1'b1 || entry !== 16'h0005) begin
            n_fail++;
            $display("FAIL held_digit: got c=%b entry=%h want 1 0005", bus.load_new_c, entry);
        end
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_validity;
        logic [15:0] vals[4];
        logic        ok[4];
        vals = '{16'h2359, 16'h2400, 16'h1959, 16'h0960};
        ok   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            enter4(vals[i]);
            step(KEY_TIME, 1'b0);
            n_tests++;
            if (bus.load_new_c !== ok[i] || bus.entry_error !== !ok[i]) begin
                n_fail++;
                $display("FAIL validity_%h: got c=%b err=%b want c=%b err=%b",
                         vals[i], bus.load_new_c, bus.entry_error, ok[i], !ok[i]);
            end
            step(KEY_NONE, 1'b0);
        end
        step(4'hC, 1'b0);
        n_tests++;
        if (bus.show_new_time !== 1'b0 || entry !== 16'h0960) begin
            n_fail++;
            $display("FAIL ignored_key: got show_new=%b entry=%h want 0 0960", bus.show_new_time, entry);
        end
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_timeout;
        press_digit(4'd1, 2);
        for (int i = 1; i <= 10; i++) begin
            step(KEY_NONE, 1'b1);
            if (i == 9) begin
                n_tests++;
                if (bus.show_new_time !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_early: show_new got %b want 1 after pulse 9", bus.show_new_time);
                end
            end
            if (i == 10) begin
                n_tests++;
                if (bus.show_new_time !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_fire: show_new got %b want 0 after pulse 10", bus.show_new_time);
                end
            end
        end
        step(KEY_TIME, 1'b0);
        n_tests++;
        if (bus.load_new_c !== 1'b0 || bus.entry_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_load: got c=%b err=%b want 0 0", bus.load_new_c, bus.entry_error);
        end
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_reset_mid;
        press_digit(4'd1, 2);
        press_digit(4'd2, 2);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.show_new_time !== 1'b0 || entry !== 16'h0000 || bus.load_new_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_entry_mid: got show_new=%b entry=%h c=%b want 0 0000 0",
                     bus.show_new_time, entry, bus.load_new_c);
        end
        @(negedge clk);
        reset = 1'b1;
        press_digit(4'd1, 2);
        press_digit(4'd2, 2);
        step(KEY_TIME, 1'b0);
        n_tests++;
        if (bus.load_new_c !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_load: got c=%b want 1", bus.load_new_c);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.load_new_c !== 1'b0 || entry !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_drop_load: got c=%b entry=%h want 0 0000", bus.load_new_c, entry);
        end
        @(negedge clk);
        reset = 1'b1;
        step(KEY_NONE, 1'b0);
    endtask

    task automatic test_show_alarm;
        int cnt;
        cnt = 0;
        repeat (5) begin
            step(KEY_ALARM, 1'b0);
            if (bus.show_a === 1'b1) cnt++;
        end
        step(KEY_NONE, 1'b0);
        if (bus.show_a === 1'b1) cnt++;
        step(KEY_NONE, 1'b0);
        if (bus.show_a === 1'b1) cnt++;
        n_tests++;
        if (cnt != 5) begin
            n_fail++;
            $display("FAIL show_alarm_len: got %0d cycles want 5", cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set_time();
        test_set_alarm();
        test_error();
        test_held_digit();
        test_validity();
        test_timeout();
        test_reset_mid();
        test_show_alarm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
